// File: rtl/cnn_conv_accum_if.sv
// Handshake bundle between the product stream, the accumulator and the
// activation buffer. The product source and the result sink use the master
// side. The accumulator uses the slave side.
interface cnn_conv_accum_if #(
    parameter int PROD_WIDTH  = 41,
    parameter int BIAS_WIDTH  = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 6,
    parameter int CNT_WIDTH   = 12
);
    logic                          prod_valid;
    logic signed [PROD_WIDTH-1:0]  prod;
    logic                          prod_last;
    logic                          prod_ready;
    logic signed [BIAS_WIDTH-1:0]  cfg_bias;
    logic        [SHIFT_WIDTH-1:0] cfg_shift;
    logic                          cfg_relu;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [OUT_WIDTH-1:0]   out_data;
    logic                          out_sat;
    logic                          out_acc_ovf;
    logic        [CNT_WIDTH-1:0]   out_terms;

    modport master (
        output prod_valid, prod, prod_last, cfg_bias, cfg_shift, cfg_relu, out_ready,
        input  prod_ready, out_valid, out_data, out_sat, out_acc_ovf, out_terms
    );

    modport slave (
        input  prod_valid, prod, prod_last, cfg_bias, cfg_shift, cfg_relu, out_ready,
        output prod_ready, out_valid, out_data, out_sat, out_acc_ovf, out_terms
    );
endinterface

// File: rtl/cnn_conv_accum.sv
// Convolution accumulator. It sums a stream of signed products into one pixel
// with a saturating accumulator. It then adds the bias, applies round-half-up,
// does an arithmetic right shift and saturates to the output width.
// ReLU is optional. The result is sent over a valid/ready handshake.
module cnn_conv_accum #(
    parameter int PROD_WIDTH  = 41,
    parameter int ACC_WIDTH   = 48,
    parameter int BIAS_WIDTH  = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 6,
    parameter int CNT_WIDTH   = 12
) (
    input logic            clk,
    input logic            rst_n,
    cnn_conv_accum_if.slave bus
);
    typedef enum logic [1:0] {ACC, ROUND, OUT} state_t;

    // The rounding datapath is wide enough to hold acc+bias plus the largest
    // rounding increment 2^(2^SHIFT_WIDTH-2). The shift result is exact for
    // every shift amount.
    localparam int RW = ((ACC_WIDTH + 2) > ((1 << SHIFT_WIDTH) + 1)) ?
                        (ACC_WIDTH + 2) : ((1 << SHIFT_WIDTH) + 1);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [RW-1:0] OUT_MAX_W = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] OUT_MIN_W = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [RW-1:0] RW_ONE = {{(RW-1){1'b0}}, 1'b1};

    state_t state_reg, state_next;
    logic   prod_ready_c;
    logic   accept;

    logic signed [ACC_WIDTH-1:0]  acc_reg;
    logic        [CNT_WIDTH-1:0]  cnt_reg;
    logic                         acc_ovf_reg;
    logic                         first_reg;
    logic signed [BIAS_WIDTH-1:0] bias_reg;
    logic        [SHIFT_WIDTH-1:0] shift_reg;
    logic                         relu_reg;

    logic                         out_valid_reg;
    logic signed [OUT_WIDTH-1:0]  out_data_reg;
    logic                         out_sat_reg;
    logic                         out_acc_ovf_reg;
    logic        [CNT_WIDTH-1:0]  out_terms_reg;

    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH:0]   acc_sum;
    logic                        acc_clip;
    logic signed [ACC_WIDTH-1:0] acc_clamped;

    logic signed [RW-1:0]        rnd_t;
    logic signed [RW-1:0]        rnd_inc;
    logic signed [RW-1:0]        rnd_sum;
    logic signed [RW-1:0]        rnd_sh;
    logic signed [OUT_WIDTH-1:0] q_data;
    logic                        q_sat;

    assign accept = bus.prod_valid && prod_ready_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ACC;
        else        state_reg <= state_next;
    end

    // Next-state logic and ready decode
    always_comb begin
        state_next   = state_reg;
        prod_ready_c = 1'b0;
        case (state_reg)
            ACC: begin
                prod_ready_c = 1'b1;
                if (bus.prod_valid && bus.prod_last) state_next = ROUND;
            end
            ROUND:   state_next = OUT;
            OUT:     if (bus.out_ready) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    // Saturating accumulate: detect overflow from the two top bits of the wide sum
    always_comb begin
        prod_ext    = {{(ACC_WIDTH-PROD_WIDTH){bus.prod[PROD_WIDTH-1]}}, bus.prod};
        acc_sum     = {acc_reg[ACC_WIDTH-1], acc_reg} + {prod_ext[ACC_WIDTH-1], prod_ext};
        acc_clip    = acc_sum[ACC_WIDTH] ^ acc_sum[ACC_WIDTH-1];
        acc_clamped = acc_sum[ACC_WIDTH-1:0];
        if (acc_clip) acc_clamped = acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end

    // Bias, round half up, shift, then saturate or ReLU to the output width
    always_comb begin
        rnd_t   = {{(RW-ACC_WIDTH){acc_reg[ACC_WIDTH-1]}}, acc_reg}
                + {{(RW-BIAS_WIDTH){bias_reg[BIAS_WIDTH-1]}}, bias_reg};
        rnd_inc = (shift_reg != '0) ? (RW_ONE << (shift_reg - SHIFT_WIDTH'(1))) : '0;
        rnd_sum = rnd_t + rnd_inc;
        rnd_sh  = rnd_sum >>> shift_reg;
        q_data  = rnd_sh[OUT_WIDTH-1:0];
        q_sat   = 1'b0;
        if (relu_reg && rnd_sh[RW-1]) begin
            q_data = '0;
        end else if (rnd_sh > OUT_MAX_W) begin
            q_data = OUT_MAX_W[OUT_WIDTH-1:0];
            q_sat  = 1'b1;
        end else if (rnd_sh < OUT_MIN_W) begin
            q_data = OUT_MIN_W[OUT_WIDTH-1:0];
            q_sat  = 1'b1;
        end
    end

    // Accumulator, block bookkeeping and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg         <= '0;
            cnt_reg         <= '0;
            acc_ovf_reg     <= 1'b0;
            first_reg       <= 1'b1;
            bias_reg        <= '0;
            shift_reg       <= '0;
            relu_reg        <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_sat_reg     <= 1'b0;
            out_acc_ovf_reg <= 1'b0;
            out_terms_reg   <= '0;
        end else begin
            case (state_reg)
                ACC: begin
                    if (accept) begin
                        if (first_reg) begin
                            acc_reg     <= prod_ext;
                            bias_reg    <= bus.cfg_bias;
                            shift_reg   <= bus.cfg_shift;
                            relu_reg    <= bus.cfg_relu;
                            first_reg   <= 1'b0;
                            acc_ovf_reg <= 1'b0;
                        end else begin
                            acc_reg <= acc_clamped;
                            if (acc_clip) acc_ovf_reg <= 1'b1;
                        end
                        if (cnt_reg != {CNT_WIDTH{1'b1}}) cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                    end
                end
                ROUND: begin
                    out_data_reg    <= q_data;
                    out_sat_reg     <= q_sat;
                    out_acc_ovf_reg <= acc_ovf_reg;
                    out_terms_reg   <= cnt_reg;
                    out_valid_reg   <= 1'b1;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        acc_reg       <= '0;
                        cnt_reg       <= '0;
                        acc_ovf_reg   <= 1'b0;
                        first_reg     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.prod_ready  = prod_ready_c;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_data    = out_data_reg;
    assign bus.out_sat     = out_sat_reg;
    assign bus.out_acc_ovf = out_acc_ovf_reg;
    assign bus.out_terms   = out_terms_reg;
endmodule

// File: tb/tb_cnn_conv_accum.sv
// Bench for cnn_conv_accum. A block-level arithmetic model checks the DUT on
// every negative clock edge. Directed blocks also check hand-computed results.
module tb_cnn_conv_accum;
    localparam longint AMAX = (longint'(1) <<< 47) - 1;
    localparam longint AMIN = -(longint'(1) <<< 47);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    cnn_conv_accum_if #(.PROD_WIDTH(41), .BIAS_WIDTH(32), .OUT_WIDTH(16),
                        .SHIFT_WIDTH(6), .CNT_WIDTH(12)) bus ();

    cnn_conv_accum #(.PROD_WIDTH(41), .ACC_WIDTH(48), .BIAS_WIDTH(32), .OUT_WIDTH(16),
                     .SHIFT_WIDTH(6), .CNT_WIDTH(12)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Model state: pixel sum, captured config, pending result
    longint m_acc, m_bias;
    int     m_shift, m_terms, m_wait;
    bit     m_relu, m_ovf, m_first, m_busy;
    longint e_data, e_terms;
    bit     e_sat, e_ovf;

    // Model the block's pixel arithmetic and check the DUT outputs every cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            m_acc = 0; m_terms = 0; m_ovf = 0; m_first = 1; m_busy = 0; m_wait = 0;
            chk("rst_ready", bus.prod_ready, 1);
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_data", bus.out_data, 0);
            chk("rst_sat", bus.out_sat, 0);
            chk("rst_ovf", bus.out_acc_ovf, 0);
            chk("rst_terms", bus.out_terms, 0);
        end else begin
            chk("prod_ready", bus.prod_ready, !m_busy);
            chk("out_valid", bus.out_valid, m_busy && m_wait == 0);
            if (m_busy && m_wait == 0) begin
                chk("m_data", bus.out_data, e_data);
                chk("m_sat", bus.out_sat, e_sat);
                chk("m_ovf", bus.out_acc_ovf, e_ovf);
                chk("m_terms", bus.out_terms, e_terms);
            end
            if (!m_busy) begin
                if (bus.prod_valid) begin
                    longint v, s, t;
                    v = longint'(bus.prod);
                    if (m_first) begin
                        m_acc = v; m_bias = longint'(bus.cfg_bias);
                        m_shift = int'(bus.cfg_shift); m_relu = bus.cfg_relu;
                        m_first = 0; m_ovf = 0;
                    end else begin
                        s = m_acc + v;
                        if (s > AMAX) begin s = AMAX; m_ovf = 1; end
                        else if (s < AMIN) begin s = AMIN; m_ovf = 1; end
                        m_acc = s;
                    end
                    if (m_terms < 4095) m_terms++;
                    if (bus.prod_last) begin
                        t = m_acc + m_bias;
                        if (m_shift > 0) t = t + (longint'(1) <<< (m_shift - 1));
                        t = t >>> m_shift;
                        e_sat = 0;
                        if (m_relu && t < 0) t = 0;
                        else if (t > 32767) begin t = 32767; e_sat = 1; end
                        else if (t < -32768) begin t = -32768; e_sat = 1; end
                        e_data = t; e_ovf = m_ovf; e_terms = m_terms;
                        m_busy = 1; m_wait = 1;
                        m_acc = 0; m_terms = 0; m_ovf = 0; m_first = 1;
                    end
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (bus.out_ready) begin
                m_busy = 0;
            end
        end
    end

    // Present one product; entered and left at posedge+1
    task automatic drive_term(input longint v, input bit last);
        int guard = 0;
        bus.prod_valid = 1'b1;
        bus.prod = 41'(v);
        bus.prod_last = last;
        @(negedge clk);
        while (!bus.prod_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        bus.prod_valid = 1'b0;
        bus.prod_last = 1'b0;
    endtask

    task automatic run_block(input longint q[$], input longint bias, input int shift, input bit relu);
        bus.cfg_bias = 32'(bias);
        bus.cfg_shift = 6'(shift);
        bus.cfg_relu = relu;
        foreach (q[i]) drive_term(q[i], i == q.size() - 1);
    endtask

    task automatic expect_out(input string name, input longint d, input bit s, input bit o, input longint n);
        int k = 0;
        @(negedge clk);
        while (!bus.out_valid && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_valid"}, bus.out_valid, 1);
        chk({name, "_data"}, bus.out_data, d);
        chk({name, "_sat"}, bus.out_sat, s);
        chk({name, "_ovf"}, bus.out_acc_ovf, o);
        chk({name, "_terms"}, bus.out_terms, n);
        $display("block %s: data=%0d sat=%0b ovf=%0b terms=%0d", name, bus.out_data,
                 bus.out_sat, bus.out_acc_ovf, bus.out_terms);
    endtask

    task automatic ack();
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        longint q[$];
        longint pmax;
        pmax = (longint'(1) <<< 40) - 1;
        bus.prod_valid = 1'b0; bus.prod = '0; bus.prod_last = 1'b0;
        bus.cfg_bias = '0; bus.cfg_shift = '0; bus.cfg_relu = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        q = {100, 200, -50};       run_block(q, 10, 2, 0); expect_out("basic", 65, 0, 0, 3);      ack();
        q = {-6};                  run_block(q, 0, 2, 0);  expect_out("negrnd", -1, 0, 0, 1);     ack();
        q = {-6};                  run_block(q, 0, 2, 1);  expect_out("relu", 0, 0, 0, 1);        ack();
        q = {pmax};                run_block(q, 0, 0, 0);  expect_out("satpos", 32767, 1, 0, 1);  ack();
        q = {-(pmax + 1)};         run_block(q, 0, 0, 0);  expect_out("satneg", -32768, 1, 0, 1); ack();
        q = {-5};                  run_block(q, 0, 60, 0); expect_out("bigshift", 0, 0, 0, 1);    ack();
        q = {};
        for (int i = 0; i < 130; i++) q.push_back(pmax);
        run_block(q, 0, 47, 0);    expect_out("accsat", 1, 0, 1, 130); ack();

        // Backpressure: hold the result while a product waits upstream
        q = {1000, 24};            run_block(q, 0, 3, 0);  expect_out("bp", 128, 0, 0, 2);
        @(posedge clk); #1;
        bus.cfg_bias = '0; bus.cfg_shift = '0; bus.cfg_relu = 1'b0;
        bus.prod_valid = 1'b1; bus.prod = 41'sd7; bus.prod_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_data", bus.out_data, 128);
            chk("bp_hold_ready", bus.prod_ready, 0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(posedge clk); #1 bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_ready_after_ack", bus.prod_ready, 1);
        @(posedge clk); #1;
        bus.prod_valid = 1'b0; bus.prod_last = 1'b0;
        expect_out("bp_next", 7, 0, 0, 1); ack();

        // Reset in the middle of a block discards the partial sum
        bus.cfg_bias = 32'sd100; bus.cfg_shift = '0;
        drive_term(5, 0);
        drive_term(6, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", bus.prod_ready, 1);
        @(posedge clk); #1 rst_n = 1'b1;
        q = {7};                   run_block(q, 0, 0, 0);  expect_out("afterrst", 7, 0, 0, 1);   ack();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
